// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: bundles the clock-time inputs, raw keys, arm switch and the
// alarm outputs (alarm time, mode, buzzer, snooze flag) into one port.
// master = time/key source side, slave = alarm_ctrl side.
interface alarm_ctrl_if;
  logic [7:0] Hour;       // current hour, BCD 00-23
  logic [7:0] Minute;     // current minute, BCD 00-59
  logic [7:0] Second;     // current second, BCD 00-59
  logic       SetKey;     // raw push-button, active high
  logic       IncKey;     // raw push-button, active high
  logic       SnoozeKey;  // raw push-button, active high
  logic       AlarmOn;    // arm switch, level
  logic [7:0] AlmHour;    // alarm hour, BCD
  logic [7:0] AlmMinute;  // alarm minute, BCD
  logic [1:0] Mode;       // 00 RUN, 01 SET_HR, 10 SET_MIN
  logic       Ring;       // buzzer drive
  logic       Snoozed;    // high while snoozing

  modport master (
    output Hour, Minute, Second, SetKey, IncKey, SnoozeKey, AlarmOn,
    input  AlmHour, AlmMinute, Mode, Ring, Snoozed
  );

  modport slave (
    input  Hour, Minute, Second, SetKey, IncKey, SnoozeKey, AlarmOn,
    output AlmHour, AlmMinute, Mode, Ring, Snoozed
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: debounces three keys, edits a BCD alarm time, and sequences
// ringing / snooze / timeout against the running BCD clock time.
// Latency: key press acts DEB_CYC+2 cycles after first sampled high; Ring
// rises 2 cycles after Second becomes 00. No backpressure: level inputs only.
// Ports: _1kHzIN clock, nCR async active-low reset, bus (alarm_ctrl_if.slave).
// Optional macro ALARM_BEEP_EN: modulate Ring with a BEEP_HALF-cycle divider.
module alarm_ctrl #(
  parameter int DEB_CYC     = 20,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_SEC  = 300,
  parameter int SNOOZE_MAX  = 3,
  parameter int SET_TIMEOUT = 10
`ifdef ALARM_BEEP_EN
  ,
  parameter int BEEP_HALF   = 250
`endif
) (
  input  logic         _1kHzIN,
  input  logic         nCR,
  alarm_ctrl_if.slave  bus
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int TW   = $clog2(SET_TIMEOUT + 1);
  localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(SNOOZE_MAX + 1);

  typedef enum logic [1:0] {M_RUN = 2'b00, M_SET_HR = 2'b01, M_SET_MIN = 2'b10} mode_e;
  typedef enum logic [1:0] {R_IDLE = 2'b00, R_RING = 2'b01, R_SNOOZE = 2'b10} ring_e;

  // ---------------- key debounce (bit 0 Set, 1 Inc, 2 Snooze) ----------------
  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync2_q, db_q, press_q;
  logic [2:0][DW-1:0] deb_cnt_q;

  assign raw = {bus.SnoozeKey, bus.IncKey, bus.SetKey};

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] != db_q[k]) begin
          // accept the new level on the DEB_CYC-th consecutive differing cycle
          if (deb_cnt_q[k] == DW'(DEB_CYC - 1)) begin
            db_q[k]      <= sync2_q[k];
            deb_cnt_q[k] <= '0;
            press_q[k]   <= sync2_q[k];  // pulse on 0->1 only
          end else begin
            deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
          end
        end else begin
          deb_cnt_q[k] <= '0;
        end
      end
    end
  end

  logic set_p, inc_p, snz_p;
  assign set_p = press_q[0];
  assign inc_p = press_q[1];
  assign snz_p = press_q[2];

  // ---------------- state ----------------
  logic [7:0]    sec_q;
  logic          tick_q;
  mode_e         mode_q, mode_d;
  logic [7:0]    alm_hr_q, alm_hr_d, alm_min_q, alm_min_d;
  logic [TW-1:0] to_q, to_d;
  ring_e         ring_q, ring_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          ring_out_q, ring_out_d, snz_out_q;
  logic          set_fwd, match;

  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
    if (v == top)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // SetKey belongs to the ring FSM whenever an alarm event is active
  assign set_fwd = set_p && (ring_q == R_IDLE);

  // sec_q/tick_q already reflect the new second, so this fires once per minute
  assign match = bus.AlarmOn && (mode_q == M_RUN) && (bus.Hour == alm_hr_q) &&
                 (bus.Minute == alm_min_q) && (sec_q == 8'h00) && tick_q;

  always_comb begin
    mode_d    = mode_q;
    alm_hr_d  = alm_hr_q;
    alm_min_d = alm_min_q;
    to_d      = to_q;
    if (set_fwd) begin
      unique case (mode_q)
        M_RUN:    mode_d = M_SET_HR;
        M_SET_HR: mode_d = M_SET_MIN;
        default:  mode_d = M_RUN;
      endcase
      to_d = '0;
    end else if (inc_p) begin
      if (mode_q == M_SET_HR)       alm_hr_d  = inc_bcd(alm_hr_q, 8'h23);
      else if (mode_q == M_SET_MIN) alm_min_d = inc_bcd(alm_min_q, 8'h59);
      to_d = '0;
    end else if (set_p || snz_p) begin
      to_d = '0;
    end else if (tick_q && (mode_q != M_RUN)) begin
      if (to_q + 1'b1 == TW'(SET_TIMEOUT)) begin
        mode_d = M_RUN;
        to_d   = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_comb begin
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    scnt_d = scnt_q;
    if (!bus.AlarmOn) begin
      ring_d = R_IDLE;
    end else begin
      unique case (ring_q)
        R_IDLE: if (match) begin
          ring_d = R_RING;
          rcnt_d = '0;
          scnt_d = '0;
        end
        R_RING: begin
          if (set_p) begin
            ring_d = R_IDLE;
          end else if (snz_p && (scnt_q < SW'(SNOOZE_MAX))) begin
            ring_d = R_SNOOZE;
            scnt_d = scnt_q + 1'b1;
            rcnt_d = '0;
          end else if (tick_q) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_d == CW'(RING_SEC)) ring_d = R_IDLE;
          end
        end
        R_SNOOZE: begin
          if (set_p) begin
            ring_d = R_IDLE;
          end else if (tick_q) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_d == CW'(SNOOZE_SEC)) begin
              ring_d = R_RING;
              rcnt_d = '0;
            end
          end
        end
        default: ring_d = R_IDLE;
      endcase
    end
  end

`ifdef ALARM_BEEP_EN
  localparam int BW = $clog2(BEEP_HALF + 1);
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    beep_d     = beep_q;
    if ((ring_d == R_RING) && (ring_q != R_RING)) begin
      beep_cnt_d = '0;      // restart high on every entry to ringing
      beep_d     = 1'b1;
    end else if (ring_q == R_RING) begin
      if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
        beep_cnt_d = '0;
        beep_d     = ~beep_q;
      end else begin
        beep_cnt_d = beep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign ring_out_d = (ring_d == R_RING) && beep_d;
`else
  assign ring_out_d = (ring_d == R_RING);
`endif

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) begin
      sec_q      <= 8'h00;
      tick_q     <= 1'b0;
      mode_q     <= M_RUN;
      alm_hr_q   <= 8'h07;
      alm_min_q  <= 8'h00;
      to_q       <= '0;
      ring_q     <= R_IDLE;
      rcnt_q     <= '0;
      scnt_q     <= '0;
      ring_out_q <= 1'b0;
      snz_out_q  <= 1'b0;
    end else begin
      sec_q      <= bus.Second;
      tick_q     <= (bus.Second != sec_q);
      mode_q     <= mode_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      to_q       <= to_d;
      ring_q     <= ring_d;
      rcnt_q     <= rcnt_d;
      scnt_q     <= scnt_d;
      ring_out_q <= ring_out_d;
      snz_out_q  <= (ring_d == R_SNOOZE);
    end
  end

  assign bus.AlmHour   = alm_hr_q;
  assign bus.AlmMinute = alm_min_q;
  assign bus.Mode      = mode_q;
  assign bus.Ring      = ring_out_q;
  assign bus.Snoozed   = snz_out_q;

endmodule
